seg_scan_mux: RTL and testbench

- Parametrised time-multiplexed driver for common-select seven-segment (plus dot) displays. Generalises the fixed 6-digit scanner to N digits.
- Adds:
  - anti-ghosting dead time per slot;
  - 16-level brightness via per-slot on-window;
  - per-digit blank and flash masks, with flash timing derived internally from the frame count;
  - tear-free data latching at slot start;
  - configurable pin polarities.
- Sits between the per-digit segment encoders/flash logic and the display pins. Replaces the external flash clock.

---
 rtl/seg_scan_mux.sv | 240 ++++++++++++++++++++++++
 tb/tb_seg_scan_mux.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_mux.sv
// -----------------------------------------------------------------------------
// seg_scan_mux
//
// Time-multiplexed driver for common-select seven-segment (plus dot) displays.
// It scans DIGITS digits one slot at a time. Each slot is SCAN_CYCLES clocks
// long and starts with BLANK_CYCLES of dead time, during which every select is
// inactive so the previous digit cannot ghost into the next one. After the
// dead time the digit is lit for an on-window whose length follows
// `brightness` (16 levels).
//
// Flash timing is generated here from the frame count. The flash phase flips
// every FLASH_FRAMES completed frames, so no external flash clock is needed.
//
// The digit word, its blank/flash mask bits and the on-window length are
// captured at the start of each slot. Upstream logic may therefore change
// them at any time without tearing a slot that is already being shown.
//
// Ports
//   clk          system clock
//   rst          synchronous reset, active-high
//   en           scan enable; while low, the scanner is parked at digit 0
//                and the pins are dark
//   seg_data_in  DIGITS x SEG_W digit words, digit i at [i*SEG_W +: SEG_W],
//                already in pin polarity (passed through unmodified)
//   blank_mask   bit i = 1: digit i is never enabled
//   flash_mask   bit i = 1: digit i is dark during the flash-off phase
//   brightness   0..15 on-window level
//   seg_sel      digit enables (polarity per SEL_ACTIVE_LOW)
//   seg_data     segment pins (polarity per SEG_ACTIVE_LOW)
//   frame_tick   one-cycle pulse after each completed frame
//
// All outputs are registered. The pins in cycle t+1 reflect the counter
// state in cycle t.
// -----------------------------------------------------------------------------
module seg_scan_mux #(
    parameter int DIGITS       = 6,
    parameter int SEG_W        = 8,
    parameter int SCAN_CYCLES  = 41667,
    parameter int BLANK_CYCLES = 2000,
    parameter int FLASH_FRAMES = 120,
    parameter bit SEL_ACTIVE_LOW = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [DIGITS*SEG_W-1:0] seg_data_in,
    input  logic [DIGITS-1:0]       blank_mask,
    input  logic [DIGITS-1:0]       flash_mask,
    input  logic [3:0]              brightness,
    output logic [DIGITS-1:0]       seg_sel,
    output logic [SEG_W-1:0]        seg_data,
    output logic                    frame_tick
);

    // -------------------------------------------------------------------------
    // Derived sizes
    // -------------------------------------------------------------------------
    // Length of the region after the dead time that may be lit.
    localparam int ACTIVE = SCAN_CYCLES - BLANK_CYCLES;

    localparam int SLOT_W = (SCAN_CYCLES > 1)  ? $clog2(SCAN_CYCLES)  : 1;
    localparam int IDX_W  = $clog2(DIGITS);
    localparam int FRM_W  = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
    localparam int LEN_W  = $clog2(ACTIVE + 1);
    // Wide enough for ACTIVE * 16, so the product is never truncated
    // before the divide by 16.
    localparam int PROD_W = $clog2(ACTIVE * 16 + 1);
    // Wide enough for BLANK_CYCLES + on_len, which can equal SCAN_CYCLES.
    localparam int CMP_W  = $clog2(SCAN_CYCLES + 1);

    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_CYCLES - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);
    localparam logic [FRM_W-1:0]  FRM_LAST  = FRM_W'(FLASH_FRAMES - 1);

    localparam logic [DIGITS-1:0] SEL_OFF  = {DIGITS{SEL_ACTIVE_LOW}};
    localparam logic [SEG_W-1:0]  DATA_OFF = {SEG_W{SEG_ACTIVE_LOW}};

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [SLOT_W-1:0] r_slot_cnt;
    logic [IDX_W-1:0]  r_digit_idx;
    logic [FRM_W-1:0]  r_frame_cnt;
    logic              r_flash_phase;   // 1 = visible

    // Per-slot captures (valid from the cycle after slot start onwards).
    logic [SEG_W-1:0]  r_word;
    logic              r_blank;
    logic              r_flash;
    logic [LEN_W-1:0]  r_on_len;

    // Output registers.
    logic [DIGITS-1:0] r_seg_sel;
    logic [SEG_W-1:0]  r_seg_data;
    logic              r_frame_tick;

    // -------------------------------------------------------------------------
    // Counter events
    // -------------------------------------------------------------------------
    logic w_slot_start;
    logic w_slot_end;
    logic w_digit_last;
    logic w_frame_wrap;
    logic w_flash_wrap;

    assign w_slot_start = (r_slot_cnt == '0);
    assign w_slot_end   = (r_slot_cnt == SLOT_LAST);
    assign w_digit_last = (r_digit_idx == IDX_LAST);
    assign w_frame_wrap = w_slot_end && w_digit_last;
    assign w_flash_wrap = (r_frame_cnt == FRM_LAST);

    // -------------------------------------------------------------------------
    // Live values for the current digit
    // -------------------------------------------------------------------------
    logic [SEG_W-1:0] w_digit_words [DIGITS];

    for (genvar g = 0; g < DIGITS; g++) begin : g_words
        assign w_digit_words[g] = seg_data_in[g*SEG_W +: SEG_W];
    end

    logic [SEG_W-1:0]  w_live_word;
    logic              w_live_blank;
    logic              w_live_flash;
    logic [PROD_W-1:0] w_prod;
    logic [LEN_W-1:0]  w_live_len;

    assign w_live_word  = w_digit_words[r_digit_idx];
    assign w_live_blank = blank_mask[r_digit_idx];
    assign w_live_flash = flash_mask[r_digit_idx];

    // ACTIVE * (brightness + 1), written as ACTIVE*b + ACTIVE so that no
    // 5-bit intermediate is needed. The divide by 16 is a plain shift.
    assign w_prod     = PROD_W'(ACTIVE) * PROD_W'(brightness) + PROD_W'(ACTIVE);
    assign w_live_len = LEN_W'(w_prod >> 4);

    // -------------------------------------------------------------------------
    // Effective per-slot values
    // -------------------------------------------------------------------------
    // In the slot-start cycle the captures are still being loaded, so the
    // live values are used directly. This keeps BLANK_CYCLES = 0 correct,
    // because the drive window can then begin in the slot-start cycle.
    logic [SEG_W-1:0] w_eff_word;
    logic             w_eff_blank;
    logic             w_eff_flash;
    logic [LEN_W-1:0] w_eff_len;

    assign w_eff_word  = w_slot_start ? w_live_word  : r_word;
    assign w_eff_blank = w_slot_start ? w_live_blank : r_blank;
    assign w_eff_flash = w_slot_start ? w_live_flash : r_flash;
    assign w_eff_len   = w_slot_start ? w_live_len   : r_on_len;

    // -------------------------------------------------------------------------
    // Drive window
    // -------------------------------------------------------------------------
    logic [CMP_W-1:0] w_slot_ext;
    logic [CMP_W-1:0] w_win_end;
    logic             w_past_blank;
    logic             w_in_window;
    logic             w_flash_dark;
    logic             w_drive;

    assign w_slot_ext = CMP_W'(r_slot_cnt);
    assign w_win_end  = CMP_W'(BLANK_CYCLES) + CMP_W'(w_eff_len);

    if (BLANK_CYCLES == 0) begin : g_no_dead_time
        assign w_past_blank = 1'b1;
    end else begin : g_dead_time
        assign w_past_blank = (w_slot_ext >= CMP_W'(BLANK_CYCLES));
    end

    // An empty window (on_len = 0) makes w_win_end equal BLANK_CYCLES, so the
    // digit stays dark for the whole slot.
    assign w_in_window  = w_past_blank && (w_slot_ext < w_win_end);
    assign w_flash_dark = w_eff_flash && !r_flash_phase;
    assign w_drive      = w_in_window && !w_eff_blank && !w_flash_dark;

    // Select pattern for the current digit, in pin polarity.
    logic [DIGITS-1:0] w_sel_onehot;
    logic [DIGITS-1:0] w_sel_drive;

    assign w_sel_onehot = DIGITS'(1) << r_digit_idx;
    assign w_sel_drive  = SEL_ACTIVE_LOW ? ~w_sel_onehot : w_sel_onehot;

    // -------------------------------------------------------------------------
    // Sequential logic
    // -------------------------------------------------------------------------
    // en = 0 behaves like reset, so that the next enable starts at digit 0,
    // slot_cnt 0, with the full dead time.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            r_slot_cnt    <= '0;
            r_digit_idx   <= '0;
            r_frame_cnt   <= '0;
            r_flash_phase <= 1'b1;
            r_seg_sel     <= SEL_OFF;
            r_seg_data    <= DATA_OFF;
            r_frame_tick  <= 1'b0;
        end else begin
            r_frame_tick <= w_frame_wrap;

            if (w_slot_end) begin
                r_slot_cnt  <= '0;
                r_digit_idx <= w_digit_last ? '0 : r_digit_idx + IDX_W'(1);
            end else begin
                r_slot_cnt  <= r_slot_cnt + SLOT_W'(1);
            end

            if (w_frame_wrap) begin
                if (w_flash_wrap) begin
                    r_frame_cnt   <= '0;
                    r_flash_phase <= ~r_flash_phase;
                end else begin
                    r_frame_cnt   <= r_frame_cnt + FRM_W'(1);
                end
            end

            if (w_slot_start) begin
                r_word   <= w_live_word;
                r_blank  <= w_live_blank;
                r_flash  <= w_live_flash;
                r_on_len <= w_live_len;
            end

            // Select and data always update together.
            if (w_drive) begin
                r_seg_sel  <= w_sel_drive;
                r_seg_data <= w_eff_word;
            end else begin
                r_seg_sel  <= SEL_OFF;
                r_seg_data <= DATA_OFF;
            end
        end
    end

    assign seg_sel    = r_seg_sel;
    assign seg_data   = r_seg_data;
    assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seg_scan_mux.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_mux
//
// Bench for seg_scan_mux with 4 digits, 10-cycle slots, 2 dead cycles,
// 2-frame flash half-period, and both polarities active-low.
//
// The reference model tracks a single count `n` of enabled cycles since the
// scan started. Slot position, digit and frame are derived from n with
// division and modulo. Per-slot captures are taken when the slot offset
// is 0.
// -----------------------------------------------------------------------------
module tb_seg_scan_mux;

    localparam int DIGITS = 4;
    localparam int SEG_W  = 8;
    localparam int SCAN   = 10;
    localparam int BLANK  = 2;
    localparam int FLASH  = 2;
    localparam logic [31:0] DATA_DEF = 32'hB0A4_F9C0;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    en;
    logic [DIGITS*SEG_W-1:0] seg_data_in;
    logic [DIGITS-1:0]       blank_mask;
    logic [DIGITS-1:0]       flash_mask;
    logic [3:0]              brightness;
    logic [DIGITS-1:0]       seg_sel;
    logic [SEG_W-1:0]        seg_data;
    logic                    frame_tick;

    seg_scan_mux #(
        .DIGITS(DIGITS), .SEG_W(SEG_W), .SCAN_CYCLES(SCAN),
        .BLANK_CYCLES(BLANK), .FLASH_FRAMES(FLASH),
        .SEL_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .seg_data_in(seg_data_in),
        .blank_mask(blank_mask), .flash_mask(flash_mask),
        .brightness(brightness), .seg_sel(seg_sel), .seg_data(seg_data),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // ---------------- reference model ----------------
    int         n = 0;
    logic [7:0] m_word = 8'hFF;
    bit         m_blank = 1'b0;
    bit         m_flash = 1'b0;
    int         m_len = 0;
    logic [3:0] exp_sel;
    logic [7:0] exp_data;
    logic       exp_tick;

    // Compute the expected pins after the next edge from the current inputs.
    task automatic model_step();
        int slot;
        int idx;
        int frame;
        bit visible;
        bit lit;
        if (rst || !en) begin
            exp_sel  = 4'hF;
            exp_data = 8'hFF;
            exp_tick = 1'b0;
            n = 0;
        end else begin
            slot  = n % SCAN;
            idx   = (n / SCAN) % DIGITS;
            frame = n / (SCAN * DIGITS);
            if (slot == 0) begin
                m_word  = seg_data_in[idx*SEG_W +: SEG_W];
                m_blank = blank_mask[idx];
                m_flash = flash_mask[idx];
                m_len   = ((SCAN - BLANK) * (int'(brightness) + 1)) / 16;
            end
            visible = ((frame / FLASH) % 2) == 0;
            lit = (slot >= BLANK) && (slot < BLANK + m_len) && !m_blank &&
                  !(m_flash && !visible);
            if (lit) begin
                exp_sel  = ~(4'b0001 << idx);
                exp_data = m_word;
            end else begin
                exp_sel  = 4'hF;
                exp_data = 8'hFF;
            end
            exp_tick = (slot == SCAN - 1) && (idx == DIGITS - 1);
            n++;
        end
    endtask

    // One clock: update the model, take the edge, compare all pins.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        checks++;
        if (seg_sel !== exp_sel || seg_data !== exp_data || frame_tick !== exp_tick) begin
            errors++;
            $display("FAIL pins n=%0d: got sel=%b data=%h tick=%b, want sel=%b data=%h tick=%b",
                     n, seg_sel, seg_data, frame_tick, exp_sel, exp_data, exp_tick);
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic set_defaults();
        seg_data_in = DATA_DEF;
        blank_mask  = '0;
        flash_mask  = '0;
        brightness  = 4'd15;
    endtask

    // ---------------- vector tables ----------------
    typedef struct {
        int         cyc;
        logic [3:0] sel;
        logic [7:0] data;
        logic       tk;
    } vec_t;

    typedef struct {
        logic [3:0]       br;
        logic [3:0]       bm;
        logic [3:0]       fm;
        logic [3:0][3:0]  cnt;   // expected lit cycles per digit in one frame
    } bvec_t;

    vec_t  v[$];
    bvec_t bv[$];

    int cnt[DIGITS];
    int ticks_seen;
    int vi;
    int exp_flash[6] = '{8, 8, 0, 0, 8, 8};

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        set_defaults();

        // Cycle k = k-th clock after en rises; the pins then show slot
        // offset (k-1) % 10 of digit ((k-1) / 10) % 4.
        v.push_back('{1,  4'hF, 8'hFF, 1'b0});
        v.push_back('{2,  4'hF, 8'hFF, 1'b0});
        v.push_back('{3,  4'hE, 8'hC0, 1'b0});
        v.push_back('{10, 4'hE, 8'hC0, 1'b0});
        v.push_back('{11, 4'hF, 8'hFF, 1'b0});
        v.push_back('{13, 4'hD, 8'hF9, 1'b0});
        v.push_back('{20, 4'hD, 8'hF9, 1'b0});
        v.push_back('{23, 4'hB, 8'hA4, 1'b0});
        v.push_back('{33, 4'h7, 8'hB0, 1'b0});
        v.push_back('{39, 4'h7, 8'hB0, 1'b0});
        v.push_back('{40, 4'h7, 8'hB0, 1'b1});
        v.push_back('{41, 4'hF, 8'hFF, 1'b0});
        v.push_back('{43, 4'hE, 8'hC0, 1'b0});
        v.push_back('{80, 4'h7, 8'hB0, 1'b1});

        // Active window = 8 cycles; lit count = floor(8*(b+1)/16).
        bv.push_back('{4'd15, 4'b0000, 4'b0000, 16'h8888});
        bv.push_back('{4'd7,  4'b0000, 4'b0000, 16'h4444});
        bv.push_back('{4'd0,  4'b0000, 4'b0000, 16'h0000});
        bv.push_back('{4'd3,  4'b0000, 4'b0000, 16'h2222});
        bv.push_back('{4'd1,  4'b0000, 4'b0000, 16'h1111});
        bv.push_back('{4'd12, 4'b1010, 4'b0000, 16'h0606});
        bv.push_back('{4'd15, 4'b0100, 4'b0000, 16'h8088});
        bv.push_back('{4'd15, 4'b0000, 4'b1111, 16'h8888});

        // ---- reset state ----
        do_reset();
        check("reset_sel",  {28'd0, seg_sel}, 32'hF);
        check("reset_data", {24'd0, seg_data}, 32'hFF);
        check("reset_tick", {31'd0, frame_tick}, 32'h0);

        // ---- basic scan order and frame tick ----
        en = 1'b1;
        vi = 0;
        for (int k = 1; k <= 80; k++) begin
            tick();
            while (vi < v.size() && v[vi].cyc == k) begin
                check($sformatf("scan_sel_c%0d", k),  {28'd0, seg_sel},    {28'd0, v[vi].sel});
                check($sformatf("scan_data_c%0d", k), {24'd0, seg_data},   {24'd0, v[vi].data});
                check($sformatf("scan_tick_c%0d", k), {31'd0, frame_tick}, {31'd0, v[vi].tk});
                vi++;
            end
        end

        // ---- brightness / blank table ----
        foreach (bv[i]) begin
            do_reset();
            set_defaults();
            brightness = bv[i].br;
            blank_mask = bv[i].bm;
            flash_mask = bv[i].fm;
            en = 1'b1;
            for (int d = 0; d < DIGITS; d++) cnt[d] = 0;
            ticks_seen = 0;
            for (int k = 0; k < SCAN * DIGITS; k++) begin
                tick();
                for (int d = 0; d < DIGITS; d++) if (!seg_sel[d]) cnt[d]++;
                if (frame_tick) ticks_seen++;
            end
            for (int d = 0; d < DIGITS; d++)
                check($sformatf("lit_b%0d_d%0d", bv[i].br, d), cnt[d], {28'd0, bv[i].cnt[d]});
            check($sformatf("frame_ticks_v%0d", i), ticks_seen, 32'd1);
        end

        // ---- flash: digit 0 lit frames 0-1, dark 2-3, lit 4-5 ----
        do_reset();
        set_defaults();
        flash_mask = 4'b0001;
        en = 1'b1;
        for (int f = 0; f < 6; f++) begin
            cnt[0] = 0;
            cnt[1] = 0;
            for (int k = 0; k < SCAN * DIGITS; k++) begin
                tick();
                if (!seg_sel[0]) cnt[0]++;
                if (!seg_sel[1]) cnt[1]++;
            end
            check($sformatf("flash_d0_f%0d", f), cnt[0], exp_flash[f]);
            check($sformatf("flash_d1_f%0d", f), cnt[1], 32'd8);
        end

        // ---- tear-free latching: digit 1 changes at slot-1 offset 5 ----
        do_reset();
        set_defaults();
        en = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (k == 15) seg_data_in[15:8] = 8'h99;
            if (k == 18 || k == 20) begin
                check($sformatf("latch_old_sel_c%0d", k), {28'd0, seg_sel}, 32'hD);
                check($sformatf("latch_old_data_c%0d", k), {24'd0, seg_data}, 32'hF9);
            end
            if (k == 53 || k == 60) begin
                check($sformatf("latch_new_sel_c%0d", k), {28'd0, seg_sel}, 32'hD);
                check($sformatf("latch_new_data_c%0d", k), {24'd0, seg_data}, 32'h99);
            end
        end

        // ---- reset mid-slot (slot 2 offset 6) ----
        do_reset();
        set_defaults();
        en = 1'b1;
        for (int k = 1; k <= 26; k++) tick();
        rst = 1'b1;
        tick();
        check("midrst_sel",  {28'd0, seg_sel}, 32'hF);
        check("midrst_data", {24'd0, seg_data}, 32'hFF);
        check("midrst_tick", {31'd0, frame_tick}, 32'h0);
        rst = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            if (k < 3) check($sformatf("rst_dead_c%0d", k), {28'd0, seg_sel}, 32'hF);
            else begin
                check("rst_restart_sel",  {28'd0, seg_sel}, 32'hE);
                check("rst_restart_data", {24'd0, seg_data}, 32'hC0);
            end
        end

        // ---- en = 0 mid-frame ----
        for (int k = 0; k < 14; k++) tick();
        en = 1'b0;
        tick();
        check("en_off_sel",  {28'd0, seg_sel}, 32'hF);
        check("en_off_data", {24'd0, seg_data}, 32'hFF);
        for (int k = 0; k < 4; k++) tick();
        en = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (k == 2)  check("en_dead_sel", {28'd0, seg_sel}, 32'hF);
            if (k == 3)  check("en_restart_sel", {28'd0, seg_sel}, 32'hE);
            if (k == 40) check("en_restart_tick", {31'd0, frame_tick}, 32'h1);
        end

        // ---- randomized run against the model ----
        do_reset();
        set_defaults();
        en = 1'b1;
        for (int k = 0; k < 1500; k++) begin
            rst = ($urandom_range(0, 299) == 0);
            en  = ($urandom_range(0, 59) != 0);
            if ($urandom_range(0, 3) == 0) seg_data_in = $urandom;
            if ($urandom_range(0, 7) == 0) blank_mask = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) flash_mask = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 5) == 0) brightness = 4'($urandom_range(0, 15));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
